// File: rtl/audio_clock_gen.sv
// Multi-channel phase-accumulator clock generator: one NCO per channel with
// glitch-free increment updates at wrap boundaries and a configuration lock flag.
module audio_clock_gen #(
  parameter int NUM_CLOCKS = 2,
  parameter int ACC_WIDTH = 24,
  parameter int LOCK_CYCLES = 256,
  parameter logic [ACC_WIDTH-1:0] DEFAULT_INC = '0,
  localparam int SEL_WIDTH = (NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1
) (
  input  logic                  refclk,
  input  logic                  rst_n,
  input  logic                  cfg_wr,
  input  logic [SEL_WIDTH-1:0]  cfg_sel,
  input  logic [ACC_WIDTH-1:0]  cfg_inc,
  input  logic [NUM_CLOCKS-1:0] en,
  input  logic                  sync,
  output logic [NUM_CLOCKS-1:0] outclk,
  output logic [NUM_CLOCKS-1:0] tick,
  output logic                  locked
);

  localparam logic [SEL_WIDTH:0] NUM_SEL = (SEL_WIDTH + 1)'(NUM_CLOCKS);
  localparam logic [15:0] LOCK_VAL = 16'(LOCK_CYCLES);

  logic                  wr_ok;
  logic [NUM_CLOCKS-1:0] pend_valid_next;
  logic [15:0]           lock_cnt_reg;
  logic [15:0]           lock_cnt_next;
  logic                  locked_reg;

  // Out-of-range channel selects are dropped entirely, so they never disturb lock.
  assign wr_ok = cfg_wr && ({1'b0, cfg_sel} < NUM_SEL);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CLOCKS; gi++) begin : g_ch
      localparam logic [SEL_WIDTH-1:0] CH_SEL = SEL_WIDTH'(gi);

      logic [ACC_WIDTH-1:0] acc_reg;
      logic [ACC_WIDTH-1:0] inc_reg;
      logic [ACC_WIDTH-1:0] pend_reg;
      logic                 pend_valid_reg;
      logic                 outclk_reg;
      logic                 tick_reg;
      logic [ACC_WIDTH:0]   sum;
      logic                 carry;
      logic                 wr_hit;
      logic                 xfer;

      assign sum    = {1'b0, acc_reg} + {1'b0, inc_reg};
      assign carry  = sum[ACC_WIDTH] & en[gi] & ~sync;
      assign wr_hit = wr_ok && (cfg_sel == CH_SEL);
      // Swap at a wrap so the running period finishes intact; if no wrap can
      // come (stopped or zero increment) or a sync realigns, swap right away.
      assign xfer   = pend_valid_reg &
                      (carry | sync | ~en[gi] | (inc_reg == '0));

      // A write that lands with a transfer becomes the next pending value.
      assign pend_valid_next[gi] = wr_hit | (pend_valid_reg & ~xfer);

      always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
          acc_reg        <= '0;
          inc_reg        <= DEFAULT_INC;
          pend_reg       <= '0;
          pend_valid_reg <= 1'b0;
          outclk_reg     <= 1'b0;
          tick_reg       <= 1'b0;
        end else begin
          if (sync) begin
            acc_reg <= '0;
          end else if (en[gi]) begin
            acc_reg <= sum[ACC_WIDTH-1:0];
          end
          if (xfer) begin
            inc_reg <= pend_reg;
          end
          if (wr_hit) begin
            pend_reg <= cfg_inc;
          end
          pend_valid_reg <= pend_valid_next[gi];
          outclk_reg     <= acc_reg[ACC_WIDTH-1];
          tick_reg       <= carry;
        end
      end

      assign outclk[gi] = outclk_reg;
      assign tick[gi]   = tick_reg;
    end
  endgenerate

  always_comb begin
    lock_cnt_next = lock_cnt_reg;
    if (wr_ok || sync) begin
      lock_cnt_next = '0;
    end else if (lock_cnt_reg != LOCK_VAL) begin
      lock_cnt_next = lock_cnt_reg + 16'd1;
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      lock_cnt_reg <= '0;
      locked_reg   <= 1'b0;
    end else begin
      lock_cnt_reg <= lock_cnt_next;
      locked_reg   <= (lock_cnt_next == LOCK_VAL) && !(|pend_valid_next);
    end
  end

  assign locked = locked_reg;

endmodule
